// File: rtl/ws_seq_pkg.sv
// Shared types and instruction field map for the weight-stationary sequencer.
package ws_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      W_RD,
      W_LD,
      KFL,
      A_RD,
      EXE,
      DRN,
      FIN
   } state_t;

   localparam int INST_W = 57;

   // Bit positions inside the core instruction packet
   localparam int B_KFLUSH   = 0;
   localparam int B_EXECUTE  = 1;
   localparam int B_L0_WR    = 2;
   localparam int B_L0_RD    = 3;
   localparam int B_OFIFO_RD = 6;
   localparam int B_A_XMEM   = 7;
   localparam int B_WEN_XMEM = 18;
   localparam int B_CEN_XMEM = 19;
   localparam int B_A_PMEM   = 20;
   localparam int B_WEN_PMEM = 31;
   localparam int B_CEN_PMEM = 32;
   localparam int B_LD_MODE  = 35;
   localparam int B_OS_OR_WS = 38;
   localparam int B_OS_WEN   = 39;
   localparam int B_OS_CEN   = 40;

   // All SRAMs deselected, every strobe low, WS mode
   localparam logic [INST_W-1:0] IDLE_INST =
      (INST_W'(1) << B_OS_CEN)   | (INST_W'(1) << B_OS_WEN)   |
      (INST_W'(1) << B_CEN_PMEM) | (INST_W'(1) << B_WEN_PMEM) |
      (INST_W'(1) << B_CEN_XMEM) | (INST_W'(1) << B_WEN_XMEM);

endpackage

// File: rtl/ws_core_sequencer_xmem_rd_stream.sv
// Counted burst reader: issues len reads from base, then one tail cycle;
// l0_wr follows each read by one cycle to match the SRAM read latency.
module xmem_rd_stream #(
   parameter int ADDR_W = 11,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              active,
   input  logic              kill,
   input  logic [ADDR_W-1:0] base,
   input  logic [CNT_W-1:0]  len,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addr,
   output logic              l0_wr,
   output logic              last
);

   logic [CNT_W-1:0] cnt_q;
   logic             wr_p1;

   assign rd_en = active && (cnt_q < len);
   assign last  = active && (cnt_q == len);
   assign addr  = base + ADDR_W'(cnt_q);
   assign l0_wr = wr_p1;

   // Burst counter and one-cycle-delayed L0 write strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         wr_p1 <= 1'b0;
      end else begin
         wr_p1 <= rd_en && !kill;
         if (active && !kill && !last) cnt_q <= cnt_q + CNT_W'(1);
         else                          cnt_q <= '0;
      end
   end

endmodule

// File: rtl/ws_core_sequencer.sv
// Weight-stationary instruction sequencer: per kernel position loads weights,
// streams activations, executes and drains OFIFO into PSUM SRAM.
module ws_core_sequencer
   import ws_seq_pkg::*;
#(
   parameter int bw      = 4,
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int len_nij = 36,
   parameter int ADDR_W  = 11,
   parameter int inst_bw = 57,
   parameter int KLD_CYC = 16,
   parameter int KIJ_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [KIJ_W-1:0]   n_kij,
   input  logic [ADDR_W-1:0]  wt_base,
   input  logic [ADDR_W-1:0]  act_base,
   input  logic [ADDR_W-1:0]  psum_base,
   input  logic               ofifo_valid,
   output logic [inst_bw-1:0] inst,
   output logic               busy,
   output logic               done,
   output logic [KIJ_W-1:0]   kij_idx
);

   localparam int MAX_A = (len_nij > KLD_CYC) ? len_nij : KLD_CYC;
   localparam int MAX_C = (MAX_A > col) ? MAX_A : col;
   localparam int CNT_W = $clog2(MAX_C + 1);

   if (bw < 1 || row < 1 || inst_bw != INST_W) begin : g_param_err
      $error("ws_core_sequencer: unsupported parameter set");
   end

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [KIJ_W-1:0]   kij_q, kij_d, n_kij_q;
   logic [KIJ_W:0]     kij_nxt;
   logic [ADDR_W-1:0]  wt_base_q, act_base_q, psum_base_q;
   logic [ADDR_W-1:0]  pmem_addr;
   logic [inst_bw-1:0] inst_d;
   logic               done_d;

   logic               rs_active, rs_rd, rs_l0_wr, rs_last;
   logic [ADDR_W-1:0]  rs_base, rs_addr;
   logic [CNT_W-1:0]   rs_len;

   assign rs_active = (state_q == W_RD) || (state_q == A_RD);
   assign rs_base   = (state_q == W_RD) ? wt_base_q + ADDR_W'(kij_q) * ADDR_W'(col)
                                        : act_base_q;
   assign rs_len    = (state_q == W_RD) ? CNT_W'(col) : CNT_W'(len_nij);
   assign pmem_addr = psum_base_q + ADDR_W'(kij_q) * ADDR_W'(len_nij) + ADDR_W'(cnt_q);
   assign kij_nxt   = {1'b0, kij_q} + (KIJ_W + 1)'(1);
   assign busy      = (state_q != IDLE);
   assign kij_idx   = kij_q;

   xmem_rd_stream #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_rd_stream (
      .clk    (clk),
      .reset  (reset),
      .active (rs_active),
      .kill   (abort),
      .base   (rs_base),
      .len    (rs_len),
      .rd_en  (rs_rd),
      .addr   (rs_addr),
      .l0_wr  (rs_l0_wr),
      .last   (rs_last)
   );

   // Run configuration, captured only when a start is accepted
   always_ff @(posedge clk) begin
      if (state_q == IDLE && start && !abort) begin
         n_kij_q     <= n_kij;
         wt_base_q   <= wt_base;
         act_base_q  <= act_base;
         psum_base_q <= psum_base;
      end
   end

   // State, counters and the registered instruction/done outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         kij_q   <= '0;
         inst    <= IDLE_INST;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kij_q   <= kij_d;
         inst    <= inst_d;
         done    <= done_d;
      end
   end

   // Next-state and packet decode; abort overrides everything
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kij_d   = kij_q;
      inst_d  = IDLE_INST;
      done_d  = 1'b0;

      inst_d[B_L0_WR] = rs_l0_wr;
      if (rs_rd) begin
         inst_d[B_CEN_XMEM]            = 1'b0;
         inst_d[B_A_XMEM +: ADDR_W]    = rs_addr;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               kij_d   = '0;
               cnt_d   = '0;
               state_d = (n_kij == '0) ? FIN : W_RD;
            end
         end
         W_RD: if (rs_last) state_d = W_LD;
         W_LD: begin
            inst_d[B_L0_RD]   = 1'b1;
            inst_d[B_LD_MODE] = 1'b1;
            if (cnt_q == CNT_W'(KLD_CYC - 1)) begin
               cnt_d   = '0;
               state_d = KFL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         KFL: begin
            inst_d[B_KFLUSH] = 1'b1;
            state_d          = A_RD;
         end
         A_RD: if (rs_last) state_d = EXE;
         EXE: begin
            inst_d[B_L0_RD]   = 1'b1;
            inst_d[B_EXECUTE] = 1'b1;
            if (cnt_q == CNT_W'(len_nij - 1)) begin
               cnt_d   = '0;
               state_d = DRN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DRN: begin
            if (cnt_q == CNT_W'(len_nij)) begin
               cnt_d   = '0;
               kij_d   = kij_nxt[KIJ_W-1:0];
               state_d = (kij_nxt < {1'b0, n_kij_q}) ? W_RD : FIN;
            end else if (ofifo_valid) begin
               inst_d[B_OFIFO_RD]         = 1'b1;
               inst_d[B_CEN_PMEM]         = 1'b0;
               inst_d[B_WEN_PMEM]         = 1'b0;
               inst_d[B_A_PMEM +: ADDR_W] = pmem_addr;
               cnt_d                      = cnt_q + CNT_W'(1);
            end
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d = IDLE;
         cnt_d   = '0;
         kij_d   = '0;
         inst_d  = IDLE_INST;
         done_d  = 1'b0;
      end
   end

endmodule

// File: tb/tb_ws_core_sequencer.sv
// Scoreboard bench: a run-level model queues the expected non-idle packets and
// done events; a negedge monitor pops and compares whatever the DUT presents.
module tb_ws_core_sequencer;

   localparam int COL = 8;
   localparam int LEN = 36;
   localparam int KLD = 16;
   localparam int AW  = 11;
   localparam int IW  = 57;
   localparam int KIJ_CYC = (COL + 1) + KLD + 1 + (LEN + 1) + LEN + (LEN + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [3:0]    n_kij;
   logic [AW-1:0] wt_base, act_base, psum_base;
   logic          ofifo_valid;
   logic [IW-1:0] inst;
   logic          busy, done;
   logic [3:0]    kij_idx;

   typedef struct {
      logic [IW-1:0] pkt;
      int            kij;
   } exp_t;

   exp_t          exp_q[$];
   int            done_cyc_q[$];
   int            done_kij_q[$];
   logic [IW-1:0] idle_pkt;
   int            vectors = 0;
   int            miscompares = 0;
   int            cyc = 0;
   int            done_seen = 0;
   int            ofifo_mode = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ws_core_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .n_kij       (n_kij),
      .wt_base     (wt_base),
      .act_base    (act_base),
      .psum_base   (psum_base),
      .ofifo_valid (ofifo_valid),
      .inst        (inst),
      .busy        (busy),
      .done        (done),
      .kij_idx     (kij_idx)
   );

   function automatic logic [IW-1:0] mk(bit kfl, bit exe, bit l0w, bit l0r, bit ldm,
                                        bit xrd, int xa, bit pwr, int pa);
      logic [IW-1:0] p;
      logic [AW-1:0] a;
      p = '0;
      p[40] = 1'b1;  p[39] = 1'b1;  p[18] = 1'b1;
      p[19] = !xrd;  p[32] = !pwr;  p[31] = !pwr;
      p[0] = kfl;  p[1] = exe;  p[2] = l0w;  p[3] = l0r;  p[6] = pwr;  p[35] = ldm;
      if (xrd) begin a = AW'(xa % 2048); p[17:7]  = a; end
      if (pwr) begin a = AW'(pa % 2048); p[30:20] = a; end
      return p;
   endfunction

   task automatic push(logic [IW-1:0] p, int k);
      exp_t e;
      e.pkt = p;
      e.kij = k;
      exp_q.push_back(e);
   endtask

   // Expected packet stream of a complete run, in issue order
   task automatic model_run(int n, int wt, int act, int ps);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < COL; i++) push(mk(0,0,(i > 0),0,0,1,wt + k*COL + i,0,0), -1);
         push(mk(0,0,1,0,0,0,0,0,0), -1);
         for (int i = 0; i < KLD; i++) push(mk(0,0,0,1,1,0,0,0,0), -1);
         push(mk(1,0,0,0,0,0,0,0,0), -1);
         for (int i = 0; i < LEN; i++) push(mk(0,0,(i > 0),0,0,1,act + i,0,0), -1);
         push(mk(0,0,1,0,0,0,0,0,0), -1);
         for (int i = 0; i < LEN; i++) push(mk(0,1,0,1,0,0,0,0,0), -1);
         for (int i = 0; i < LEN; i++) push(mk(0,0,0,0,0,0,0,1,ps + k*LEN + i), k);
      end
   endtask

   task automatic chk(string name, logic [63:0] got, logic [63:0] expv);
      vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", name, got, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_model();
      exp_q.delete();
      done_cyc_q.delete();
      done_kij_q.delete();
   endtask

   task automatic start_run(int n, int wt, int act, int ps, bit timed);
      model_run(n, wt, act, ps);
      n_kij     = 4'(n);
      wt_base   = AW'(wt);
      act_base  = AW'(act);
      psum_base = AW'(ps);
      start     = 1'b1;
      done_cyc_q.push_back(timed ? cyc + 2 + KIJ_CYC * n : -1);
      done_kij_q.push_back(n % 16);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      int target;
      target = done_seen + 1;
      for (int i = 0; i < 6000 && done_seen < target; i++) tick();
      chk("done_reached", 64'(done_seen >= target), 64'(1));
      chk("post_done_busy_done", 64'({busy, done}), 64'(0));
   endtask

   // Monitor: every non-idle packet and every done pulse is checked against the queues
   initial begin
      exp_t e;
      int   ec, ek;
      idle_pkt = mk(0,0,0,0,0,0,0,0,0);
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) continue;
         if (inst !== idle_pkt) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL pkt_unexpected got=%h busy=%b", inst, busy);
            end else begin
               e = exp_q.pop_front();
               if (inst !== e.pkt || busy !== 1'b1 || (e.kij >= 0 && kij_idx !== 4'(e.kij))) begin
                  miscompares++;
                  $display("FAIL pkt got=%h exp=%h busy=%b kij=%0d exp_kij=%0d",
                           inst, e.pkt, busy, kij_idx, e.kij);
               end
            end
         end
         if (done !== 1'b0) begin
            vectors++;
            done_seen++;
            if (done_cyc_q.size() == 0) begin
               miscompares++;
               $display("FAIL done_unexpected got=%b exp=0 cyc=%0d", done, cyc);
            end else begin
               ec = done_cyc_q.pop_front();
               ek = done_kij_q.pop_front();
               if ((ec >= 0 && cyc != ec) || busy !== 1'b0 || kij_idx !== 4'(ek) || exp_q.size() != 0) begin
                  miscompares++;
                  $display("FAIL done cyc=%0d exp_cyc=%0d busy=%b kij=%0d exp_kij=%0d pending=%0d",
                           cyc, ec, busy, kij_idx, ek, exp_q.size());
               end
            end
         end
      end
   end

   // OFIFO availability pattern: steady, alternating or random
   initial begin
      ofifo_valid = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ofifo_mode)
            0:       ofifo_valid = 1'b1;
            1:       ofifo_valid = ~ofifo_valid;
            default: ofifo_valid = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      reset = 1'b0;  start = 1'b0;  abort = 1'b0;
      n_kij = '0;  wt_base = '0;  act_base = '0;  psum_base = '0;
      repeat (3) tick();
      chk("rst_inst", 64'(inst), 64'(idle_pkt));
      chk("rst_busy_done", 64'({busy, done}), 64'(0));
      chk("rst_kij", 64'(kij_idx), 64'(0));
      reset = 1'b1;
      tick();

      // single kernel position
      ofifo_mode = 0;
      start_run(1, 0, 100, 200, 1);
      wait_done();

      // three kernel positions
      start_run(3, 0, 100, 200, 1);
      wait_done();

      // drain with alternating ofifo_valid
      ofifo_mode = 1;
      start_run(1, 40, 500, 300, 0);
      wait_done();
      ofifo_mode = 0;

      // empty run
      start_run(0, 5, 6, 7, 1);
      wait_done();

      // address wrap on all three streams
      start_run(1, 2044, 2030, 2040, 1);
      wait_done();

      // abort during execute cycle 10, then replay
      start_run(1, 16, 64, 128, 0);
      repeat (73) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      flush_model();
      @(negedge clk);
      chk("abort_inst", 64'(inst), 64'(idle_pkt));
      chk("abort_busy_done", 64'({busy, done}), 64'(0));
      chk("abort_kij", 64'(kij_idx), 64'(0));
      repeat (5) tick();
      start_run(1, 16, 64, 128, 1);
      wait_done();

      // start while busy must not disturb the latched configuration
      start_run(2, 8, 300, 400, 1);
      repeat (109) tick();
      n_kij = 4'd5;  wt_base = 11'd1000;  act_base = 11'd1000;  psum_base = 11'd1000;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();

      // asynchronous reset while draining kernel position 1
      start_run(2, 0, 100, 200, 0);
      repeat (244) tick();
      @(negedge clk);
      chk("kij_pre_reset", 64'(kij_idx), 64'(1));
      #2;
      reset = 1'b0;
      #1;
      flush_model();
      chk("areset_inst", 64'(inst), 64'(idle_pkt));
      chk("areset_busy_done", 64'({busy, done}), 64'(0));
      chk("areset_kij", 64'(kij_idx), 64'(0));
      tick();
      tick();
      reset = 1'b1;
      tick();

      // randomized runs with random OFIFO stalls
      ofifo_mode = 2;
      for (int r = 0; r < 8; r++) begin
         start_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 2047)),
                   int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 0);
         wait_done();
         repeat ($urandom_range(0, 3)) tick();
      end

      repeat (3) tick();
      chk("final_queue_empty", 64'(exp_q.size() + done_cyc_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
